// File: rtl/matr_seq_ctrl.sv
// matr_seq_ctrl: sequences an N x N integer matrix multiply C = A * B over a
// single shared data-memory port. One element of A and one of B are fetched
// per inner step, multiplied and accumulated; each finished C element is
// written back in row-major order.
module matr_seq_ctrl #(
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic          clk_50,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   base_a,
  input  logic [31:0]   base_b,
  input  logic [31:0]   base_c,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    WT_A = 3'd2,
    RD_B = 3'd3,
    WT_B = 3'd4,
    MAC  = 3'd5,
    WR_C = 3'd6,
    DONE = 3'd7
  } state_t;

  // Highest legal row/column/inner index (N is limited to 1..8).
  localparam logic [2:0] LAST = 3'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   ba;
  logic [31:0]   bb;
  logic [31:0]   bc;
  logic [2:0]    i;
  logic [2:0]    j;
  logic [2:0]    k;
  logic [DW-1:0] acc;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] prod;

  // Byte address of element (r,c) of a row-major N x N word matrix.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input logic [2:0]  r,
                                            input logic [2:0]  c);
    logic [31:0] idx;
    idx = 32'(r) * 32'(N) + 32'(c);
    return base + {idx[29:0], 2'b00};
  endfunction

  // Product is deliberately truncated to DW bits; accumulation wraps.
  assign prod = a_reg * b_reg;

  // State register.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore outputs; outputs depend only on registers,
  // so a request holds its address and data steady while waiting for grant.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = RD_A;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_A: begin
        mem_req  = 1'b1;
        mem_addr = elem_addr(ba, i, k);
        if (mem_gnt) begin
          state_nxt = WT_A;
        end else begin
          state_nxt = RD_A;
        end
      end
      WT_A: state_nxt = RD_B;
      RD_B: begin
        mem_req  = 1'b1;
        mem_addr = elem_addr(bb, k, j);
        if (mem_gnt) begin
          state_nxt = WT_B;
        end else begin
          state_nxt = RD_B;
        end
      end
      WT_B: state_nxt = MAC;
      MAC: begin
        if (k < LAST) begin
          state_nxt = RD_A;
        end else begin
          state_nxt = WR_C;
        end
      end
      WR_C: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = elem_addr(bc, i, j);
        mem_wdata = acc;
        if (!mem_gnt) begin
          state_nxt = WR_C;
        end else if ((i == LAST) && (j == LAST)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD_A;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: base capture, loop indices, operand latches and accumulator.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      ba    <= 32'd0;
      bb    <= 32'd0;
      bc    <= 32'd0;
      i     <= 3'd0;
      j     <= 3'd0;
      k     <= 3'd0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ba  <= base_a & 32'hFFFF_FFFC;
            bb  <= base_b & 32'hFFFF_FFFC;
            bc  <= base_c & 32'hFFFF_FFFC;
            i   <= 3'd0;
            j   <= 3'd0;
            k   <= 3'd0;
            acc <= '0;
          end
        end
        WT_A: a_reg <= mem_rdata;
        WT_B: b_reg <= mem_rdata;
        MAC: begin
          acc <= acc + prod;
          if (k < LAST) begin
            k <= k + 3'd1;
          end
        end
        WR_C: begin
          if (mem_gnt) begin
            acc <= '0;
            k   <= 3'd0;
            if (j == LAST) begin
              j <= 3'd0;
              i <= i + 3'd1;
            end else begin
              j <= j + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/matr_seq_ctrl.md
MATR_SEQ_CTRL -- requirements
Module: matr_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning matrix dimension (N x N, legal 1..8).
REQ-002 SHALL have parameter DW, default 32, meaning element/data width.
REQ-003 SHALL have port clk_50  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request from decode of the matr instruction.
REQ-006 SHALL have port base_a  input  32  byte address of A[0][0] (rs1 value).
REQ-007 SHALL have port base_b  input  32  byte address of B[0][0] (rs2 value).
REQ-008 SHALL have port base_c  input  32  byte address of C[0][0] (rd value).
REQ-009 SHALL have port busy  output  1  pipeline stall request while a multiply is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_req  output  1  data-memory access request.
REQ-012 SHALL have port mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-013 SHALL have port mem_addr  output  32  byte address, word aligned.
REQ-014 SHALL have port mem_wdata  output  DW  write data.
REQ-015 SHALL have port mem_gnt  input  1  memory arbiter grant; access accepted in a cycle with mem_req=1 and mem_gnt=1.
REQ-016 SHALL have port mem_rdata  input  DW  read data, valid exactly one cycle after the granted read.

Function
REQ-017 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], row-major, element (r,c) at base + 4*(r*N+c).
REQ-018 SHALL force bits [1:0] of base_a/base_b/base_c to 0 when captured.
REQ-019 SHALL truncate each product to DW bits and accumulate modulo 2^DW; no saturation, no overflow flag.
REQ-020 SHALL implement states IDLE, RD_A, WT_A, RD_B, WT_B, MAC, WR_C, DONE.
REQ-021 IDLE: on start=1, capture bases, clear i,j,k and accumulator, go RD_A; otherwise stay.
REQ-022 RD_A: mem_req=1, mem_we=0, addr of A[i][k]; hold all outputs until mem_gnt=1, then go WT_A.
REQ-023 WT_A: latch mem_rdata into a_reg, mem_req=0, go RD_B.
REQ-024 RD_B: as RD_A for B[k][j], go WT_B on grant; WT_B latches b_reg, go MAC.
REQ-025 MAC: acc += a_reg*b_reg; if k<N-1, k++ and go RD_A; else go WR_C.
REQ-026 WR_C: mem_req=1, mem_we=1, addr of C[i][j], mem_wdata=acc; hold until grant; then clear acc and k, advance j (wrap to 0 with i++), go RD_A, or go DONE after element (N-1,N-1).
REQ-027 DONE: done=1 for exactly one cycle, go IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE; done SHALL be 1 only in DONE.
REQ-029 mem_req SHALL be 0 in IDLE, WT_A, WT_B, MAC, DONE; mem_we SHALL be 0 whenever mem_req=0.
REQ-030 start while not IDLE SHALL be ignored; bases captured only in IDLE.
REQ-031 With mem_gnt held 1, start sampled in cycle t SHALL yield done=1 in cycle t+N*N*(5N+1)+1 (t+145 for N=3).
REQ-032 Each grant wait cycle SHALL add exactly one cycle to total latency; no request dropped or reissued with different address.
REQ-033 Output order of C writes SHALL be (0,0),(0,1)...(N-1,N-1), each written exactly once.

Reset
REQ-034 rst=1 at a rising edge SHALL force state IDLE, i=j=k=0, acc=a_reg=b_reg=0, busy=done=mem_req=mem_we=0, mem_addr=mem_wdata=0.
REQ-035 rst SHALL take priority over start and mem_gnt in the same cycle.
REQ-036 rst mid-operation SHALL abort without completing writes; already-written C elements remain, no done pulse.

Verification
REQ-037 N=3, A=identity at 32, B=1..9 at 80, C base 164, mem_gnt=1 -> C words at 164..196 = 1..9, done at t+145, busy 1 for cycles t+1..t+145.
REQ-038 A all 0x00010000, B all 0x00010000 -> every C element = 0x00000000 (modulo wrap); A all 2, B all 3 -> every C = 18.
REQ-039 mem_gnt pseudo-random 50% -> same C results as REQ-037, mem_addr/mem_we stable while mem_req=1 and mem_gnt=0, latency = 145 + wait cycles.
REQ-040 start pulsed again at t+10 with different bases -> ignored, C written only at original base, single done.
REQ-041 rst asserted at t+50 -> next cycle busy=0, mem_req=0, no done; new start afterwards completes correctly.
REQ-042 N=1, A=7, B=6 -> single write of 42 to base_c, done at t+7; base_c=0x0A3 -> write to 0x0A0.
